seven_seg_scan_driver: RTL and testbench

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

---
 rtl/seven_seg_scan_driver.sv | 139 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with shadowed display data,
// hex/blank decode, leading-zero suppression and selectable polarity.
module seven_seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit HEX_MODE    = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   sh_val_q;
  logic [DIGITS-1:0]     sh_dp_q;
  logic                  sh_lz_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [DIGITS-1:0]     an_q;
  logic                  frame_q;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     hi_zero;
  logic                  blank;
  logic [6:0]            seg_ah;
  logic [DIGITS-1:0]     an_ah;
  logic                  dp_ah;

  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign tick = (cnt_q == CW'(REFRESH_DIV - 1));
  assign wrap = tick && (idx_q == IW'(DIGITS - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
  end

  // hi_zero[i]: nibble i and every nibble above it are zero
  always_comb begin
    logic z;
    hi_zero = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (sh_val_q[4*i +: 4] == 4'd0);
      hi_zero[i] = z;
    end
  end

  always_comb begin
    nib    = sh_val_q[int'(idx_q)*4 +: 4];
    blank  = (!HEX_MODE && nib > 4'd9) ||
             (sh_lz_q && idx_q != '0 && hi_zero[idx_q]);
    seg_ah = blank ? 7'd0 : seg_lut(nib);
    an_ah  = DIGITS'(1) << idx_q;
    dp_ah  = sh_dp_q[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      sh_lz_q  <= 1'b0;
    end else if (load) begin
      sh_val_q <= value;
      sh_dp_q  <= dp;
      sh_lz_q  <= lz_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= SEG_OFF;
      dp_q    <= ACTIVE_LOW;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_ah ^ SEG_OFF;
      dp_q    <= dp_ah ^ ACTIVE_LOW;
      an_q    <= an_ah ^ AN_OFF;
      frame_q <= wrap;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: three instances (hex, blanking, single
// digit) checked every clock against an arithmetic scan/decode model.
module tb_seven_seg_scan_driver;

  localparam int RDIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz_en;

  logic [6:0] seg_a, seg_h, seg_d;
  logic       dpo_a, dpo_h, dpo_d;
  logic [3:0] an_a, an_h;
  logic       an_d;
  logic       ft_a, ft_h, ft_d;

  int n_chk;
  int n_pass;
  int k;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_lz;

  logic [6:0] lut [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  seven_seg_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(RDIV), .HEX_MODE(1'b1), .ACTIVE_LOW(1'b1)
  ) u_hex (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .lz_en(lz_en), .seg(seg_a), .dp_out(dpo_a), .an(an_a),
    .frame_tick(ft_a)
  );

  seven_seg_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(RDIV), .HEX_MODE(1'b0), .ACTIVE_LOW(1'b1)
  ) u_dec (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .lz_en(lz_en), .seg(seg_h), .dp_out(dpo_h), .an(an_h),
    .frame_tick(ft_h)
  );

  seven_seg_scan_driver #(
    .DIGITS(1), .REFRESH_DIV(RDIV), .HEX_MODE(1'b1), .ACTIVE_LOW(1'b1)
  ) u_one (
    .clk(clk), .rst(rst), .value(value[3:0]), .dp(dp[0]), .load(load),
    .lz_en(lz_en), .seg(seg_d), .dp_out(dpo_d), .an(an_d),
    .frame_tick(ft_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t k=%0d)",
                  tag, obs, exp, $time, k);
  endtask

  // Output after clock edge k (counted from reset release)
  function automatic void exp_out(input int nd, input bit hex,
                                  output logic [6:0] s, output logic d,
                                  output logic [7:0] a, output logic f);
    int pos;
    int nib;
    bit blank;
    pos   = ((k - 1) / RDIV) % nd;
    nib   = int'((m_val >> (4 * pos)) & 16'hF);
    blank = (!hex && nib > 9) ||
            (m_lz && pos > 0 && (m_val >> (4 * pos)) == 16'd0);
    s = blank ? 7'h00 : lut[nib];
    s = ~s;
    d = ~m_dp[pos];
    a = ~(8'd1 << pos) & ((8'd1 << nd) - 8'd1);
    f = (k % (RDIV * nd)) == 0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_an"},  {28'd0, an_a}, 32'hF);
    chk({tag, "_seg"}, {25'd0, seg_a}, 32'h7F);
    chk({tag, "_dp"},  {31'd0, dpo_a}, 32'h1);
    chk({tag, "_ft"},  {31'd0, ft_a}, 32'h0);
    chk({tag, "_an1"}, {31'd0, an_d}, 32'h1);
  endtask

  task automatic tick_chk();
    logic [6:0] sa, sh, sd;
    logic       da, dh, dd;
    logic [7:0] aa, ah, ad;
    logic       fa, fh, fd;
    @(posedge clk);
    k++;
    exp_out(4, 1'b1, sa, da, aa, fa);
    exp_out(4, 1'b0, sh, dh, ah, fh);
    exp_out(1, 1'b1, sd, dd, ad, fd);
    if (load) begin
      m_val = value;
      m_dp  = dp;
      m_lz  = lz_en;
    end
    #1;
    chk("seg",     {25'd0, seg_a}, {25'd0, sa});
    chk("dp",      {31'd0, dpo_a}, {31'd0, da});
    chk("an",      {28'd0, an_a},  {24'd0, aa});
    chk("ft",      {31'd0, ft_a},  {31'd0, fa});
    chk("seg_dec", {25'd0, seg_h}, {25'd0, sh});
    chk("dp_dec",  {31'd0, dpo_h}, {31'd0, dh});
    chk("an_dec",  {28'd0, an_h},  {24'd0, ah});
    chk("seg_1d",  {25'd0, seg_d}, {25'd0, sd});
    chk("dp_1d",   {31'd0, dpo_d}, {31'd0, dd});
    chk("an_1d",   {31'd0, an_d},  {24'd0, ad});
    chk("ft_1d",   {31'd0, ft_d},  {31'd0, fd});
  endtask

  task automatic load_run(input logic [15:0] v, input logic [3:0] p,
                          input logic lz, input int n);
    value = v;
    dp    = p;
    lz_en = lz;
    load  = 1'b1;
    tick_chk();
    load  = 1'b0;
    repeat (n) tick_chk();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    k      = 0;
    m_val  = '0;
    m_dp   = '0;
    m_lz   = 1'b0;
    rst    = 1'b1;
    value  = '0;
    dp     = '0;
    load   = 1'b0;
    lz_en  = 1'b0;
    #1;
    chk_idle("rst0");
    repeat (2) @(posedge clk);
    #1;
    chk_idle("rst1");
    @(negedge clk);
    rst = 1'b0;

    load_run(16'h1234, 4'b0100, 1'b0, 40);
    load_run(16'h0050, 4'b0000, 1'b1, 20);
    load_run(16'hA9F0, 4'b1001, 1'b0, 20);

    // value/dp wiggle without load must not reach the outputs
    for (int i = 0; i < 20; i++) begin
      value = 16'($urandom);
      dp    = 4'($urandom);
      tick_chk();
    end

    // async reset in the middle of digit 2
    for (int i = 0; i < 40; i++) begin
      if (((k - 1) / RDIV) % 4 == 2 && (k - 1) % RDIV == 1) break;
      tick_chk();
    end
    chk("mid_digit2", 32'(((k - 1) / RDIV) % 4), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    chk_idle("arst");
    @(posedge clk);
    #1;
    chk_idle("arst_hold");
    @(negedge clk);
    rst   = 1'b0;
    k     = 0;
    m_val = '0;
    m_dp  = '0;
    m_lz  = 1'b0;
    repeat (8) tick_chk();

    for (int i = 0; i < 400; i++) begin
      value = 16'($urandom);
      dp    = 4'($urandom);
      lz_en = 1'($urandom);
      load  = ($urandom_range(0, 3) == 0);
      tick_chk();
    end
    load = 1'b0;
    repeat (16) tick_chk();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
